// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO bank: width derivation and parameter sanity checks.
package fifo_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Occupancy needs one bit more than the address to represent a completely full FIFO.
  function automatic int cnt_width(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic bit thresh_ok(input int thresh, input int depth);
    return (thresh >= 0) && (thresh <= depth);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 4) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_channel.sv
// Single synchronous FIFO with occupancy, thresholds, sticky error flags and optional FWFT read.
module fifo_channel import fifo_pkg::*; #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 128,
  parameter int AF_THRESH  = DEPTH - 8,
  parameter int AE_THRESH  = 8,
  parameter int FWFT       = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         rd_en,
  input  logic                         clear_err,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         rd_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [cnt_width(DEPTH)-1:0]  count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("fifo_channel: DEPTH=%0d must be a power of two >= 4", DEPTH);
  end
  if (!thresh_ok(AF_THRESH, DEPTH) || !thresh_ok(AE_THRESH, DEPTH)) begin : g_bad_thresh
    $error("fifo_channel: thresholds AF=%0d AE=%0d outside 0..%0d", AF_THRESH, AE_THRESH, DEPTH);
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]         wr_ptr, rd_ptr;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] head;

  // Status is decoded from the registered count, so a write is visible one cycle later.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;
  assign head   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + CW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + CW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A new error in the same cycle as clear_err must survive the clear.
      overflow  <= (wr_en && full)  || (overflow  && !clear_err);
      underflow <= (rd_en && empty) || (underflow && !clear_err);
    end
  end

  // NOTE: the storage array has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  if (FWFT != 0) begin : g_fwft
    assign rd_data  = head;
    assign rd_valid = !empty;
  end else begin : g_registered
    always_ff @(posedge clk) begin
      if (reset) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) rd_data <= head;
      end
    end
  end

endmodule

// File: rtl/fifo_bank.sv
// Bank of independent per-channel FIFOs sharing clock, reset and error-clear.
module fifo_bank import fifo_pkg::*; #(
  parameter int DATA_WIDTH = 256,
  parameter int CHANNELS   = 32,
  parameter int DEPTH      = 128,
  parameter int AF_THRESH  = DEPTH - 8,
  parameter int AE_THRESH  = 8,
  parameter int FWFT       = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [CHANNELS-1:0]                    wr_en,
  input  logic [CHANNELS*DATA_WIDTH-1:0]         wr_data,
  input  logic [CHANNELS-1:0]                    rd_en,
  output logic [CHANNELS*DATA_WIDTH-1:0]         rd_data,
  output logic [CHANNELS-1:0]                    rd_valid,
  output logic [CHANNELS-1:0]                    full,
  output logic [CHANNELS-1:0]                    empty,
  output logic [CHANNELS-1:0]                    almost_full,
  output logic [CHANNELS-1:0]                    almost_empty,
  output logic [CHANNELS*cnt_width(DEPTH)-1:0]   count,
  output logic [CHANNELS-1:0]                    overflow,
  output logic [CHANNELS-1:0]                    underflow,
  input  logic                                   clear_err
);

  localparam int CW = cnt_width(DEPTH);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    fifo_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AF_THRESH  (AF_THRESH),
      .AE_THRESH  (AE_THRESH),
      .FWFT       (FWFT)
    ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (wr_en[i]),
      .wr_data      (wr_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .rd_en        (rd_en[i]),
      .clear_err    (clear_err),
      .rd_data      (rd_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .rd_valid     (rd_valid[i]),
      .full         (full[i]),
      .empty        (empty[i]),
      .almost_full  (almost_full[i]),
      .almost_empty (almost_empty[i]),
      .count        (count[i*CW +: CW]),
      .overflow     (overflow[i]),
      .underflow    (underflow[i])
    );
  end

endmodule
